// File: rtl/lpdec_pkg.sv
// lp_decode_pipe shared types: opcodes, ALU ops, control word, FSM states.
// Build macro LPDEC_ACT_CNT_EN enables the control-activity counter.
package lpdec_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_ST  = 4'd7;
  localparam logic [3:0] OP_BR  = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_SLL = 4'd10;
  localparam logic [3:0] OP_SRL = 4'd11;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_NOP = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
    logic    illegal;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SLEEP  = 2'd2
  } state_e;

  localparam ctrl_word_t CTRL_NOP = '{
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_src:   1'b0,
    branch:    1'b0,
    jump:      1'b0,
    alu_op:    ALU_NOP,
    illegal:   1'b0
  };

  function automatic ctrl_word_t decode_op(
    input logic [3:0] op,
    input logic       hi_set
  );
    ctrl_word_t w;
    w = CTRL_NOP;
    if (hi_set) begin
      w.illegal = 1'b1;
    end else begin
      unique case (1'b1)
        op == OP_NOP: w = CTRL_NOP;
        op == OP_ADD: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_ADD;
        end
        op == OP_SUB: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_SUB;
        end
        op == OP_AND: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_AND;
        end
        op == OP_OR: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_OR;
        end
        op == OP_XOR: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_XOR;
        end
        op == OP_LD: begin
          w.reg_write = 1'b1;
          w.mem_read  = 1'b1;
          w.alu_src   = 1'b1;
          w.alu_op    = ALU_ADD;
        end
        op == OP_ST: begin
          w.mem_write = 1'b1;
          w.alu_src   = 1'b1;
          w.alu_op    = ALU_ADD;
        end
        op == OP_BR: begin
          w.branch = 1'b1;
          w.alu_op = ALU_SUB;
        end
        op == OP_JMP: w.jump = 1'b1;
        op == OP_SLL: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_SLL;
        end
        op == OP_SRL: begin
          w.reg_write = 1'b1;
          w.alu_op    = ALU_SRL;
        end
        default: w.illegal = 1'b1;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/lpdec_ctrl_fifo.sv
// Control-word buffer; when empty the output keeps the last popped word
// so downstream control lines do not toggle.
module lpdec_ctrl_fifo
  import lpdec_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ctrl_word_t wdata,
  input  logic       pop,
  output ctrl_word_t rdata,
  output logic       valid,
  output logic       full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_word_t    mem [FIFO_DEPTH];
  ctrl_word_t    hold_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign rdata   = valid ? mem[rd_ptr] : hold_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= CTRL_NOP;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        hold_q <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lp_decode_pipe.sv
// Low-power decode pipe: opcode decode, control-word buffer, sleep FSM.
// Build macro LPDEC_ACT_CNT_EN adds the act_cnt activity counter port.
module lp_decode_pipe
  import lpdec_pkg::*;
#(
  parameter int OPC_W       = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int IDLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPC_W-1:0] opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             branch,
  output logic             jump,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic             sleep
`ifdef LPDEC_ACT_CNT_EN
  ,
  output logic [15:0]      act_cnt
`endif
);

  localparam logic [7:0] IDLE_LIM = 8'(IDLE_CYCLES);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] idle_cnt_q;
  logic [7:0] idle_cnt_d;
  logic       hi_set;
  logic       full;
  logic       push;
  logic       pop;
  logic       idle_cond;
  ctrl_word_t dec_word;
  ctrl_word_t head;

  generate
    if (OPC_W > 4) begin : g_hi
      assign hi_set = |opcode[OPC_W-1:4];
    end else begin : g_no_hi
      assign hi_set = 1'b0;
    end
  endgenerate

  assign dec_word  = decode_op(opcode[3:0], hi_set);
  assign in_ready  = !full && (state_q != ST_SLEEP);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign idle_cond = !in_valid && !out_valid;
  assign sleep     = (state_q == ST_SLEEP);

  lpdec_ctrl_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (dec_word),
    .pop   (pop),
    .rdata (head),
    .valid (out_valid),
    .full  (full)
  );

  assign reg_write = head.reg_write;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign alu_src   = head.alu_src;
  assign branch    = head.branch;
  assign jump      = head.jump;
  assign alu_op    = head.alu_op;
  assign illegal   = head.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACTIVE;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      ST_ACTIVE: begin
        idle_cnt_d = '0;
        if (idle_cond) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end else if (idle_cond) begin
          idle_cnt_d = idle_cnt_q + 8'd1;
          if (idle_cnt_d == IDLE_LIM) begin
            state_d = ST_SLEEP;
          end
        end
      end
      ST_SLEEP: begin
        // wake only; the instruction is taken next cycle
        if (in_valid) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_ACTIVE;
        idle_cnt_d = '0;
      end
    endcase
  end

`ifdef LPDEC_ACT_CNT_EN
  ctrl_word_t prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= CTRL_NOP;
      act_cnt <= '0;
    end else begin
      prev_q <= head;
      if ((head != prev_q) && (act_cnt != 16'hFFFF)) begin
        act_cnt <= act_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
